// File: rtl/fir_tap_sequencer_if.sv
// Sample, coefficient-write and MAC-beat link of fir_tap_sequencer.
// The master modport is the sequencer side; slave is the upstream source plus the MAC.
interface fir_tap_sequencer_if #(
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18,
  parameter int ADDR_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]  sample_in;
  logic                   sample_valid;
  logic                   sample_ready;
  logic                   coeff_wr_en;
  logic [ADDR_WIDTH-1:0]  coeff_wr_addr;
  logic [COEFF_WIDTH-1:0] coeff_wr_data;
  logic [DATA_WIDTH-1:0]  mac_data;
  logic [COEFF_WIDTH-1:0] mac_coeff;
  logic                   mac_valid;
  logic                   mac_ready;
  logic                   mac_clear_acc;
  logic                   mac_last;

  modport master (
    input  sample_in, sample_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data, mac_ready,
    output sample_ready, mac_data, mac_coeff, mac_valid, mac_clear_acc, mac_last
  );

  modport slave (
    output sample_in, sample_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data, mac_ready,
    input  sample_ready, mac_data, mac_coeff, mac_valid, mac_clear_acc, mac_last
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepted sample -> clear beat at T+1, tap k at T+2+k; beats hold while mac_ready=0.
// Registered outputs follow enable one cycle late. Define FIR_SEQ_DECIM_EN to sweep only every DECIM-th sample.
module fir_tap_sequencer #(
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18,
  parameter int NUM_TAPS    = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int DECIM       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  fir_tap_sequencer_if.master bus,
  output logic [15:0]         status
);
  typedef enum logic [1:0] {IDLE, CLEAR, TAPS} state_t;

  localparam logic [ADDR_WIDTH:0]   NT       = (ADDR_WIDTH+1)'(NUM_TAPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAPS - 1);

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  dline_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0]  dline_d [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] coeff_d [NUM_TAPS];
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, newest_q, newest_d, tap_q, tap_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   dropped_q, dropped_d;
  logic                   sample_ready_q, sample_ready_d;
  logic                   mac_valid_q, mac_valid_d;
  logic [DATA_WIDTH-1:0]  mac_data_q, mac_data_d;
  logic [COEFF_WIDTH-1:0] mac_coeff_q, mac_coeff_d;
  logic                   mac_clear_q, mac_clear_d;
  logic                   mac_last_q, mac_last_d;

  logic                   accept, hs, sweep;
  logic [ADDR_WIDTH-1:0]  ld_tap;

  assign accept = bus.sample_valid & sample_ready_q;
  assign hs     = mac_valid_q & bus.mac_ready;
  assign ld_tap = (state_q == TAPS && tap_q != LAST_TAP) ? tap_q + ADDR_WIDTH'(1) : '0;

  // Position of the sample k steps older than the newest one; NUM_TAPS need not be a power of 2.
  function automatic logic [ADDR_WIDTH-1:0] hist_idx(input logic [ADDR_WIDTH-1:0] newest,
                                                     input logic [ADDR_WIDTH-1:0] k);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, newest} + NT - {1'b0, k};
    if (s >= NT) s = s - NT;
    return s[ADDR_WIDTH-1:0];
  endfunction

`ifdef FIR_SEQ_DECIM_EN
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [PW-1:0] phase_q, phase_d;

  assign sweep = (phase_q == PW'(DECIM - 1));

  always_comb begin
    phase_d = phase_q;
    if (accept) phase_d = sweep ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end
`else
  logic unused_decim;
  assign unused_decim = |DECIM;
  assign sweep        = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    dline_d        = dline_q;
    coeff_d        = coeff_q;
    wr_ptr_d       = wr_ptr_q;
    newest_d       = newest_q;
    tap_d          = tap_q;
    cnt_d          = cnt_q;
    dropped_d      = dropped_q;
    sample_ready_d = sample_ready_q;
    mac_valid_d    = mac_valid_q;
    mac_data_d     = mac_data_q;
    mac_coeff_d    = mac_coeff_q;
    mac_clear_d    = mac_clear_q;
    mac_last_d     = mac_last_q;

    // Landing in the accept cycle lets the sweep that follows see the new coefficient.
    if (bus.coeff_wr_en) begin
      if (state_q == IDLE && {1'b0, bus.coeff_wr_addr} < NT) coeff_d[bus.coeff_wr_addr] = bus.coeff_wr_data;
      else                                                 dropped_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        sample_ready_d = enable;
        mac_valid_d    = 1'b0;
        if (accept) begin
          dline_d[wr_ptr_q] = bus.sample_in;
          newest_d          = wr_ptr_q;
          wr_ptr_d          = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
          cnt_d             = cnt_q + 8'd1;
          if (sweep) begin
            state_d        = CLEAR;
            sample_ready_d = 1'b0;
            mac_valid_d    = enable;
            mac_data_d     = '0;
            mac_coeff_d    = '0;
            mac_clear_d    = 1'b1;
            mac_last_d     = 1'b0;
          end
        end
      end
      CLEAR, TAPS: begin
        sample_ready_d = 1'b0;
        mac_valid_d    = enable;
        if (hs) begin
          if (state_q == TAPS && tap_q == LAST_TAP) begin
            state_d        = IDLE;
            sample_ready_d = enable;
            mac_valid_d    = 1'b0;
            mac_data_d     = '0;
            mac_coeff_d    = '0;
            mac_last_d     = 1'b0;
          end else begin
            state_d     = TAPS;
            tap_d       = ld_tap;
            mac_data_d  = dline_q[hist_idx(newest_q, ld_tap)];
            mac_coeff_d = coeff_q[ld_tap];
            mac_clear_d = 1'b0;
            mac_last_d  = (ld_tap == LAST_TAP);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_TAPS; i++) begin
        dline_q[i] <= '0;
        coeff_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      newest_q       <= '0;
      tap_q          <= '0;
      cnt_q          <= '0;
      dropped_q      <= 1'b0;
      sample_ready_q <= 1'b0;
      mac_valid_q    <= 1'b0;
      mac_data_q     <= '0;
      mac_coeff_q    <= '0;
      mac_clear_q    <= 1'b0;
      mac_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dline_q        <= dline_d;
      coeff_q        <= coeff_d;
      wr_ptr_q       <= wr_ptr_d;
      newest_q       <= newest_d;
      tap_q          <= tap_d;
      cnt_q          <= cnt_d;
      dropped_q      <= dropped_d;
      sample_ready_q <= sample_ready_d;
      mac_valid_q    <= mac_valid_d;
      mac_data_q     <= mac_data_d;
      mac_coeff_q    <= mac_coeff_d;
      mac_clear_q    <= mac_clear_d;
      mac_last_q     <= mac_last_d;
    end
  end

  assign bus.sample_ready  = sample_ready_q;
  assign bus.mac_valid     = mac_valid_q;
  assign bus.mac_data      = mac_data_q;
  assign bus.mac_coeff     = mac_coeff_q;
  assign bus.mac_clear_acc = mac_clear_q;
  assign bus.mac_last      = mac_last_q;
  assign status            = {cnt_q, 5'b0, mac_valid_q & ~bus.mac_ready, dropped_q, state_q != IDLE};
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized scoreboard bench for fir_tap_sequencer: the stimulus side queues expected beats, the monitor pops on each handshake.
module tb_fir_tap_sequencer;
  localparam int DW = 18, CW = 18, N = 5, AW = 3, DECIM = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          clr;
    logic          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] status;

  fir_tap_sequencer_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

  fir_tap_sequencer #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(N), .ADDR_WIDTH(AW), .DECIM(DECIM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus.master), .status(status)
  );

  always #5 clk = ~clk;

  int            checks = 0, failures = 0, sweeps_done = 0, tmo_cnt = 0, acc_cnt = 0;
  beat_t         sb[$];
  logic [DW-1:0] hist[$];
  logic [CW-1:0] coeff_m [N];
  logic          dropped_m = 1'b0, sweeping = 1'b0, en_prev = 1'b0;
  logic          end_req = 1'b0, end_done = 1'b0, do_sweep;
  beat_t         b, exp_b;
  logic [15:0]   exp_status;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of accepted samples, coefficient table, and the beats each sweep must produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", {bus.mac_valid, bus.sample_ready, bus.mac_clear_acc, bus.mac_last, status}, '0);
      chk("reset_bus", {bus.mac_data, bus.mac_coeff}, '0);
      sb.delete();
      hist.delete();
      foreach (coeff_m[i]) coeff_m[i] = '0;
      dropped_m = 1'b0;
      sweeping  = 1'b0;
      en_prev   = 1'b0;
      acc_cnt   = 0;
    end else begin
      exp_status = {8'(acc_cnt), 5'b0, sweeping && en_prev && !bus.mac_ready, dropped_m, sweeping};
      chk("sample_ready", bus.sample_ready, !sweeping && en_prev);
      chk("mac_valid", bus.mac_valid, sweeping && en_prev);
      chk("status", status, exp_status);

      if (bus.coeff_wr_en) begin
        if (!sweeping && int'(bus.coeff_wr_addr) < N) coeff_m[bus.coeff_wr_addr] = bus.coeff_wr_data;
        else                                          dropped_m = 1'b1;
      end

      if (bus.mac_valid && bus.mac_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_beat", sb.size(), 1);
        end else begin
          exp_b = sb.pop_front();
          chk("beat", {bus.mac_data, bus.mac_coeff, bus.mac_clear_acc, bus.mac_last}, exp_b);
          if (exp_b.last) begin
            sweeping = 1'b0;
            sweeps_done++;
          end
        end
      end

      if (bus.sample_valid && bus.sample_ready) begin
        acc_cnt++;
        hist.push_back(bus.sample_in);
        if (hist.size() > N) void'(hist.pop_front());
        do_sweep = 1'b1;
`ifdef FIR_SEQ_DECIM_EN
        do_sweep = (acc_cnt % DECIM == 0);
`endif
        if (do_sweep) begin
          b     = '0;
          b.clr = 1'b1;
          sb.push_back(b);
          for (int k = 0; k < N; k++) begin
            b.d    = (k < hist.size()) ? hist[hist.size() - 1 - k] : '0;
            b.c    = coeff_m[k];
            b.clr  = 1'b0;
            b.last = (k == N - 1);
            sb.push_back(b);
          end
          sweeping = 1'b1;
        end
      end
      en_prev = enable;
    end

    if (end_req && !end_done) begin
      chk("sb_drained", sb.size(), 0);
      chk("push_timeouts", tmo_cnt, 0);
      chk("enough_sweeps", sweeps_done >= 10, 1);
      end_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_coeff(input logic [AW-1:0] a, input logic [CW-1:0] v);
    bus.coeff_wr_en   = 1'b1;
    bus.coeff_wr_addr = a;
    bus.coeff_wr_data = v;
    step();
    bus.coeff_wr_en   = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] s);
    int t;
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    for (t = 0; t < 200 && !bus.sample_ready; t++) step();
    if (t == 200) tmo_cnt++;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.sample_valid = 1'b0;
    bus.coeff_wr_en  = 1'b0;
    bus.mac_ready    = 1'b1;
    enable           = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    bus.sample_valid = 1'b0; bus.sample_in = '0; bus.mac_ready = 1'b0;
    bus.coeff_wr_en = 1'b0; bus.coeff_wr_addr = '0; bus.coeff_wr_data = '0;
    repeat (3) step();
    rst_n = 1'b1; enable = 1'b1; bus.mac_ready = 1'b1;
    step();

    // Ramp coefficients and samples: the last sweep walks samples N..1 against coefficients 1..N.
    for (int k = 0; k < N; k++) wr_coeff(AW'(k), CW'(k + 1));
    for (int i = 1; i <= N; i++) push(DW'(i));
    drain(2 * N + 6);

    push(DW'(18'h2a5));
    for (int i = 0; i < 3 * N + 8; i++) begin
      bus.mac_ready = ~bus.mac_ready;
      step();
    end
    drain(2 * N + 6);

    push(DW'(77));
    step();
    wr_coeff(AW'(0), CW'(999));
    drain(2 * N + 6);
    wr_coeff(AW'(N), CW'(555));
    push(DW'(9));
    drain(2 * N + 6);

    for (int i = 0; i < 2000; i++) begin
      bus.sample_valid  = ($urandom_range(0, 9) < 7);
      bus.sample_in     = DW'($urandom);
      bus.mac_ready     = ($urandom_range(0, 9) < 6);
      enable            = ($urandom_range(0, 19) != 0);
      bus.coeff_wr_en   = ($urandom_range(0, 9) == 0);
      bus.coeff_wr_addr = AW'($urandom_range(0, (1 << AW) - 1));
      bus.coeff_wr_data = CW'($urandom);
      step();
    end
    drain(2 * N + 6);

    push(DW'(123));
    repeat (3) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < N; k++) wr_coeff(AW'(k), CW'(1));
    push(DW'(5));
    drain(2 * N + 6);

    end_req = 1'b1;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
